addsub_arbiter: RTL

//  Round-robin controller sharing one RC_ADD_SUB_32 adder/subtractor among NUM_REQ requesters.

---
 rtl/addsub_arbiter_pkg.sv | 13 +
 rtl/addsub_arbiter_rr.sv | 33 +++
 rtl/addsub_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared constants and FSM encoding for the add/sub round-robin arbiter.
package addsub_arbiter_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int DATA_INDEX_LIMIT = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } arbStateT;

endpackage

// File: rtl/addsub_arbiter_rr.sv
// Combinational round-robin picker: first eligible request scanning from ptr upward, wrapping.
module rr_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               any
);

  logic [NUM_REQ-1:0] eligible;
  logic [PTR_W-1:0]   idx;

  assign eligible = req & ~mask;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && eligible[idx]) begin
        win[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one 32-bit adder/subtractor among NUM_REQ requesters.
// Define ADDSUB_OVF_EN to add the registered signed-overflow output OVF.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] A_BUS,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] B_BUS,
  input  logic [NUM_REQ-1:0]            SNA,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            ACK,
  output logic [DATA_WIDTH-1:0]         Y,
  output logic                          CO,
`ifdef ADDSUB_OVF_EN
  output logic                          OVF,
`endif
  output logic                          BUSY
);

  arbStateT               state, nextState;
  logic [PTR_W-1:0]       ptr, winIdx, arbIdx, startPtr;
  logic [NUM_REQ-1:0]     winReg, arbWin, arbMask;
  logic                   arbAny, load;
  logic [DATA_WIDTH-1:0]  opA, opB, bx;
  logic                   opSub;
  logic [DATA_WIDTH:0]    sumFull;
  logic [DATA_WIDTH-1:0]  aArr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  bArr [NUM_REQ];

  function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
    assign aArr[g] = A_BUS[g*DATA_WIDTH +: DATA_WIDTH];
    assign bArr[g] = B_BUS[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // In DONE the winner's REQ is still high; mask it and scan from the slot after it.
  assign arbMask  = (state == ST_DONE) ? winReg : '0;
  assign startPtr = (state == ST_DONE) ? incPtr(winIdx) : ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) uRr (
    .req  (REQ),
    .mask (arbMask),
    .ptr  (startPtr),
    .win  (arbWin),
    .any  (arbAny)
  );

  always_comb begin
    arbIdx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arbWin[i]) arbIdx = PTR_W'(i);
  end

  // Shared adder: subtract is A + ~B + 1.
  assign bx      = opSub ? ~opB : opB;
  assign sumFull = {1'b0, opA} + {1'b0, bx} + {{DATA_WIDTH{1'b0}}, opSub};

  always_comb begin
    nextState = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: if (arbAny) begin
        load      = 1'b1;
        nextState = ST_EXEC;
      end
      ST_EXEC: nextState = ST_DONE;
      ST_DONE: begin
        if (arbAny) begin
          load      = 1'b1;
          nextState = ST_EXEC;
        end else begin
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      winReg <= '0;
      winIdx <= '0;
      opA    <= '0;
      opB    <= '0;
      opSub  <= 1'b0;
      Y      <= '0;
      CO     <= 1'b0;
`ifdef ADDSUB_OVF_EN
      OVF    <= 1'b0;
`endif
    end else begin
      state <= nextState;
      if (load) begin
        winReg <= arbWin;
        winIdx <= arbIdx;
        opA    <= aArr[arbIdx];
        opB    <= bArr[arbIdx];
        opSub  <= SNA[arbIdx];
      end
      if (state == ST_EXEC) begin
        Y  <= sumFull[DATA_INDEX_LIMIT:0];
        CO <= sumFull[DATA_WIDTH];
`ifdef ADDSUB_OVF_EN
        OVF <= (opA[DATA_INDEX_LIMIT] == bx[DATA_INDEX_LIMIT]) &&
               (sumFull[DATA_INDEX_LIMIT] != opA[DATA_INDEX_LIMIT]);
`endif
      end
      if (state == ST_DONE) ptr <= incPtr(winIdx);
    end
  end

  assign BUSY = (state != ST_IDLE);
  assign GNT  = BUSY ? winReg : '0;
  assign ACK  = (state == ST_DONE) ? winReg : '0;

endmodule
